smac_par_acc: RTL

Pipelined, handshaked successor to the parallel SMAC datapath. Each accepted beat carries M activation/weight pairs. The block multiplies the pairs, reduces them through a registered adder tree, and accumulates the beat sums across beats until a `in_last` beat closes a dot product. It supports signed or unsigned operands per beat, flags accumulator overflow, and reports the beat count. It sits between the operand streamer and the result write-back in the MAC engine.

---
 rtl/smac_par_acc.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/smac_par_acc.sv
// Pipelined SMAC datapath: M lane products per beat, registered adder tree,
// and a cross-beat accumulator that closes a dot product on each last beat.
module smac_par_acc #(
    parameter int M         = 64,
    parameter int Pa        = 8,
    parameter int Pw        = 4,
    parameter int MAX_BEATS = 256,
    parameter int ACCW      = Pa + Pw + $clog2(M) + $clog2(MAX_BEATS),
    parameter int BCW       = $clog2(MAX_BEATS) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic                   in_signed,
    input  logic [M-1:0][Pa-1:0]   in_act,
    input  logic [M-1:0][Pw-1:0]   in_wei,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACCW-1:0]        out_sum,
    output logic                   out_ovf,
    output logic [BCW-1:0]         out_beats
);
    localparam int PRODW = Pa + Pw;
    localparam int SUMW  = PRODW + $clog2(M);
    localparam logic [BCW-1:0] CNT_ONE = BCW'(1);

    // A beat/result moves when valid && ready in the same cycle. The only
    // back-pressure source is an unconsumed result; it freezes the whole pipe.
    logic stall;
    logic out_valid_q;
    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;

    function automatic logic [PRODW-1:0] ext_act(input logic [Pa-1:0] a, input logic sgn);
        return {{Pw{sgn & a[Pa-1]}}, a};
    endfunction

    function automatic logic [PRODW-1:0] ext_wei(input logic [Pw-1:0] w, input logic sgn);
        return {{Pa{sgn & w[Pw-1]}}, w};
    endfunction

    logic                 s1_valid_q, s1_last_q, s1_signed_q;
    logic [M-1:0][Pa-1:0] s1_act_q;
    logic [M-1:0][Pw-1:0] s1_wei_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_act_q    <= '0;
            s1_wei_q    <= '0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_last_q   <= in_last;
                s1_signed_q <= in_signed;
                s1_act_q    <= in_act;
                s1_wei_q    <= in_wei;
            end
        end
    end

    // Truncating a PRODW x PRODW product to PRODW bits is exact in both modes.
    logic [M-1:0][PRODW-1:0] prod_d;
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < M; i++) begin
            prod_d[i] = ext_act(s1_act_q[i], s1_signed_q) * ext_wei(s1_wei_q[i], s1_signed_q);
        end
    end

    logic                    s2_valid_q, s2_last_q, s2_signed_q;
    logic [M-1:0][PRODW-1:0] s2_prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_signed_q <= 1'b0;
            s2_prod_q   <= '0;
        end else if (!stall) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_last_q   <= s1_last_q;
                s2_signed_q <= s1_signed_q;
                s2_prod_q   <= prod_d;
            end
        end
    end

    logic [SUMW-1:0] sum_d;
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < M; i++) begin
            sum_d = sum_d + {{(SUMW-PRODW){s2_signed_q & s2_prod_q[i][PRODW-1]}}, s2_prod_q[i]};
        end
    end

    logic            s3_valid_q, s3_last_q, s3_signed_q;
    logic [SUMW-1:0] s3_sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_signed_q <= 1'b0;
            s3_sum_q    <= '0;
        end else if (!stall) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_last_q   <= s2_last_q;
                s3_signed_q <= s2_signed_q;
                s3_sum_q    <= sum_d;
            end
        end
    end

    logic            first_q, ovf_q;
    logic [ACCW-1:0] acc_q;
    logic [BCW-1:0]  cnt_q;

    logic [ACCW-1:0] base, sum_ext, acc_d;
    logic [ACCW:0]   add_full;
    logic            ovf_step, ovf_d;
    logic [BCW-1:0]  cnt_d;

    // Overflow is judged by the mode of the beat being added, so mixed-mode
    // dot products need no extra bookkeeping.
    always_comb begin
        base     = first_q ? '0 : acc_q;
        sum_ext  = {{(ACCW-SUMW){s3_signed_q & s3_sum_q[SUMW-1]}}, s3_sum_q};
        add_full = {1'b0, base} + {1'b0, sum_ext};
        acc_d    = add_full[ACCW-1:0];
        if (s3_signed_q) begin
            ovf_step = (base[ACCW-1] == sum_ext[ACCW-1]) && (acc_d[ACCW-1] != base[ACCW-1]);
        end else begin
            ovf_step = add_full[ACCW];
        end
        ovf_d = (!first_q && ovf_q) || ovf_step;
        if (first_q) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b1;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (!stall && s3_valid_q) begin
            first_q <= s3_last_q;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [ACCW-1:0] out_sum_q;
    logic            out_ovf_q;
    logic [BCW-1:0]  out_beats_q;

    // When not stalled the old result is either absent or consumed this cycle,
    // so out_valid simply follows whether a last beat is closing now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_beats_q <= '0;
        end else if (!stall) begin
            out_valid_q <= s3_valid_q && s3_last_q;
            if (s3_valid_q && s3_last_q) begin
                out_sum_q   <= acc_d;
                out_ovf_q   <= ovf_d;
                out_beats_q <= cnt_d;
            end
        end
    end

    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign out_beats = out_beats_q;

endmodule
